// File: rtl/load_store_unit.sv
// Data-memory initiator: issues one load/store at a time on a valid/grant/response bus,
// steering byte lanes, extending load data and reporting misalignment and bus timeouts.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        bus_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 32'd0) ? $clog2(TIMEOUT_CYCLES + 32'd1) : 1;
  // The counter is cleared on entry, so the last permitted cycle sees TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       size_r;
  logic [1:0]       off_r;
  logic             unsigned_r;
  logic             write_r;
  logic             timeout_s;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_strobe(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] data);
    case (size)
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic [31:0] extract_load(input logic [1:0] size, input logic uns,
                                               input logic [1:0] off, input logic [31:0] word);
    logic [31:0] s;
    s = word >> {off, 3'b000};
    case (size)
      2'b00:   return uns ? {24'h000000, s[7:0]} : {{24{s[7]}}, s[7:0]};
      2'b01:   return uns ? {16'h0000, s[15:0]} : {{16{s[15]}}, s[15:0]};
      default: return s;
    endcase
  endfunction

  assign timeout_s = (TIMEOUT_CYCLES != 32'd0) && (cnt_r == CNT_LAST);

  // Pipeline hold: a fresh request stalls combinationally in the cycle it is presented.
  assign stall = ((state_r == IDLE) && req_valid) || (state_r == REQ) || (state_r == WAIT);

  // Transaction FSM with registered bus, completion and load-result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      size_r     <= 2'b00;
      off_r      <= 2'b00;
      unsigned_r <= 1'b0;
      write_r    <= 1'b0;
      done       <= 1'b0;
      rdata      <= 32'h0000_0000;
      misaligned <= 1'b0;
      bus_error  <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0000_0000;
      mem_wstrb  <= 4'b0000;
      mem_wdata  <= 32'h0000_0000;
    end else begin
      done       <= 1'b0;
      misaligned <= 1'b0;
      bus_error  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_valid && is_misaligned(funct3[1:0], addr[1:0])) begin
            state_r    <= RESP;
            done       <= 1'b1;
            misaligned <= 1'b1;
            rdata      <= 32'h0000_0000;
          end else if (req_valid) begin
            state_r    <= REQ;
            cnt_r      <= '0;
            size_r     <= funct3[1:0];
            off_r      <= addr[1:0];
            unsigned_r <= funct3[2];
            write_r    <= req_write;
            mem_req    <= 1'b1;
            mem_we     <= req_write;
            mem_addr   <= {addr[31:2], 2'b00};
            mem_wstrb  <= req_write ? lane_strobe(funct3[1:0], addr[1:0]) : 4'b0000;
            mem_wdata  <= lane_wdata(funct3[1:0], wdata);
          end else begin
            state_r <= IDLE;
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            cnt_r     <= '0;
            if (write_r) begin
              state_r <= RESP;
              done    <= 1'b1;
            end else begin
              state_r <= WAIT;
            end
          end else if (timeout_s) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            state_r   <= RESP;
            done      <= 1'b1;
            bus_error <= 1'b1;
            rdata     <= 32'h0000_0000;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            state_r <= RESP;
            done    <= 1'b1;
            rdata   <= extract_load(size_r, unsigned_r, off_r, mem_rdata);
          end else if (timeout_s) begin
            state_r   <= RESP;
            done      <= 1'b1;
            bus_error <= 1'b1;
            rdata     <= 32'h0000_0000;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        RESP: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized and directed bench for load_store_unit, checked every cycle against a
// transaction-level model of lane steering, extension, latency and timeout rules.
module tb_load_store_unit;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, done, misaligned, bus_error;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall), .done(done),
    .rdata(rdata), .misaligned(misaligned), .bus_error(bus_error),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int last_done_cyc = -1;
  bit chk_en = 1'b0;
  logic        last_mis, last_berr;
  logic [31:0] seen_addr, seen_wdata;
  logic [3:0]  seen_strb;

  logic        exp_stall, exp_done, exp_mis, exp_berr, exp_mem_req, exp_we;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  logic [3:0]  exp_strb;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: access width in bytes from funct3.
  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    else if (f3[1:0] == 2'b01) return 2;
    else return 4;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] s;
    int off;
    off = int'(a[1:0]);
    s = 4'b0000;
    for (int b = 0; b < 4; b++) s[b] = (b >= off) && (b < off + nbytes(f3));
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = wd[8*(b % nbytes(f3)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] w, input logic [31:0] a);
    logic [31:0] v, mask;
    int nb;
    nb = nbytes(f3);
    v = w >> (8 * int'(a[1:0]));
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    v = v & mask;
    if (nb < 4 && !f3[2] && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  // Per-cycle comparison of every meaningful output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("stall", {31'd0, stall}, {31'd0, exp_stall});
      cmp("done", {31'd0, done}, {31'd0, exp_done});
      cmp("misaligned", {31'd0, misaligned}, {31'd0, exp_mis});
      cmp("bus_error", {31'd0, bus_error}, {31'd0, exp_berr});
      cmp("mem_req", {31'd0, mem_req}, {31'd0, exp_mem_req});
      cmp("rdata", rdata, exp_rdata);
      if (exp_mem_req) begin
        cmp("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
        cmp("mem_addr", mem_addr, exp_addr);
        cmp("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, exp_strb});
        if (exp_we) cmp("mem_wdata", mem_wdata, exp_wdata);
      end
      if (done) begin
        last_done_cyc = cyc;
        last_mis = misaligned;
        last_berr = bus_error;
      end
      if (mem_req) begin
        seen_addr = mem_addr;
        seen_strb = mem_wstrb;
        seen_wdata = mem_wdata;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    exp_stall = 1'b0; exp_done = 1'b0; exp_mis = 1'b0; exp_berr = 1'b0; exp_mem_req = 1'b0;
    req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
  endtask

  task automatic junk();
    req_valid = 1'($urandom_range(0, 1));
    req_write = 1'($urandom_range(0, 1));
    funct3 = 3'($urandom_range(0, 7));
    addr = $urandom;
    wdata = $urandom;
    mem_rdata = $urandom;
  endtask

  task automatic idle();
    step();
    mem_rvalid = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
  endtask

  // One access: gd = REQ cycles before grant, rd = WAIT cycles before rvalid (>= T times out).
  task automatic access(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int gd, input int rd,
                        input logic [31:0] rw, output int lat);
    bit mis, to;
    mis = (int'(a[1:0]) % nbytes(f3)) != 0;
    to = 1'b0;
    step();
    start_cyc = cyc;
    req_valid = 1'b1; req_write = wr; funct3 = f3; addr = a; wdata = wd;
    mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    exp_stall = 1'b1;
    lat = 1;
    if (!mis) begin
      for (int k = 0; k < T; k++) begin
        step(); lat++; junk();
        mem_gnt = (k == gd);
        mem_rvalid = 1'($urandom_range(0, 1));
        exp_stall = 1'b1; exp_mem_req = 1'b1; exp_we = wr;
        exp_addr = {a[31:2], 2'b00};
        exp_strb = wr ? m_strb(f3, a) : 4'b0000;
        exp_wdata = m_wdata(f3, wd);
        if (k == gd) break;
      end
      to = (gd >= T);
      if (!to && !wr) begin
        for (int k = 0; k < T; k++) begin
          step(); lat++; junk();
          mem_rvalid = (k == rd);
          if (k == rd) mem_rdata = rw;
          exp_stall = 1'b1;
          if (k == rd) break;
        end
        to = (rd >= T);
      end
    end
    step(); junk();
    mem_rvalid = 1'($urandom_range(0, 1));
    exp_done = 1'b1; exp_mis = mis; exp_berr = to;
    if (mis || to) exp_rdata = 32'h0;
    else if (!wr) exp_rdata = m_load(f3, rw, a);
  endtask

  int lat;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; funct3 = 3'b000; addr = 32'h0;
    wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    exp_rdata = 32'h0; exp_we = 1'b0; exp_addr = 32'h0; exp_strb = 4'h0; exp_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    cmp("rst_stall", {31'd0, stall}, 32'd0);
    cmp("rst_done", {31'd0, done}, 32'd0);
    cmp("rst_mem_req", {31'd0, mem_req}, 32'd0);
    cmp("rst_rdata", rdata, 32'd0);
    cmp("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    reset = 1'b0;
    exp_stall = 1'b0; exp_done = 1'b0; exp_mis = 1'b0; exp_berr = 1'b0; exp_mem_req = 1'b0;
    chk_en = 1'b1;
    idle();

    // SB to the top byte lane.
    access(1'b1, 3'b000, 32'h103, 32'hA5, 0, 0, 32'h0, lat); idle();
    cmp("sb_addr", seen_addr, 32'h100);
    cmp("sb_wstrb", {28'd0, seen_strb}, 32'h8);
    cmp("sb_wdata", seen_wdata, 32'hA5A5A5A5);
    cmp("sb_latency", 32'(last_done_cyc - start_cyc), 32'd2);

    // LH / LHU / LB extension cases.
    access(1'b0, 3'b001, 32'h102, 32'h0, 0, 0, 32'h8001_7FFF, lat); idle();
    cmp("lh_rdata", rdata, 32'hFFFF8001);
    cmp("lh_latency", 32'(last_done_cyc - start_cyc), 32'd3);
    access(1'b0, 3'b101, 32'h102, 32'h0, 0, 0, 32'h8001_7FFF, lat); idle();
    cmp("lhu_rdata", rdata, 32'h00008001);
    access(1'b0, 3'b000, 32'h201, 32'h0, 0, 0, 32'h0000_8000, lat); idle();
    cmp("lb_rdata", rdata, 32'hFFFFFF80);

    // LW with delayed grant and response.
    access(1'b0, 3'b010, 32'h400, 32'h0, 2, 2, 32'hDEADBEEF, lat); idle();
    cmp("lw_slow_latency", 32'(last_done_cyc - start_cyc), 32'd7);
    cmp("lw_slow_rdata", rdata, 32'hDEADBEEF);

    // Misaligned SW never reaches the bus and clears rdata.
    access(1'b1, 3'b010, 32'h102, 32'h12345678, 0, 0, 32'h0, lat); idle();
    cmp("sw_mis_latency", 32'(last_done_cyc - start_cyc), 32'd1);
    cmp("sw_mis_flag", {31'd0, last_mis}, 32'd1);
    cmp("sw_mis_rdata", rdata, 32'd0);

    // Timeout after T WAIT cycles, then response on the last allowed cycle.
    access(1'b0, 3'b010, 32'h500, 32'h0, 0, 99, 32'h11112222, lat); idle();
    cmp("to_berr", {31'd0, last_berr}, 32'd1);
    cmp("to_rdata", rdata, 32'd0);
    cmp("to_latency", 32'(last_done_cyc - start_cyc), 32'd6);
    access(1'b0, 3'b010, 32'h500, 32'h0, 0, T - 1, 32'h33334444, lat); idle();
    cmp("edge_berr", {31'd0, last_berr}, 32'd0);
    cmp("edge_rdata", rdata, 32'h33334444);

    // Reset while a load is in WAIT; the stale response must be ignored.
    step();
    req_valid = 1'b1; req_write = 1'b0; funct3 = 3'b010; addr = 32'h300; wdata = 32'h0;
    exp_stall = 1'b1;
    step();
    mem_gnt = 1'b1;
    exp_stall = 1'b1; exp_mem_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h300; exp_strb = 4'h0;
    step();
    exp_stall = 1'b1;
    #2;
    chk_en = 1'b0;
    reset = 1'b1;
    #1;
    cmp("rst_mid_mem_req", {31'd0, mem_req}, 32'd0);
    cmp("rst_mid_stall", {31'd0, stall}, 32'd0);
    cmp("rst_mid_done", {31'd0, done}, 32'd0);
    exp_stall = 1'b0; exp_mem_req = 1'b0; exp_rdata = 32'h0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_en = 1'b1;
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    step();
    cmp("rst_stale_done", {31'd0, done}, 32'd0);
    access(1'b0, 3'b010, 32'h300, 32'h0, 0, 0, 32'h0BADF00D, lat); idle();
    cmp("rst_next_lw", rdata, 32'h0BADF00D);

    // Randomized accesses across sizes, offsets, delays and timeouts.
    for (int n = 0; n < 120; n++) begin
      access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
             int'($urandom_range(0, T)), int'($urandom_range(0, T)), $urandom, lat);
      repeat ($urandom_range(0, 2)) idle();
    end
    idle();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
